// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the register-file write-port arbiter: ALU/MDU writeback,
// decode hazard query, and register-file write outputs.
interface regfile_wb_arbiter_if;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mdu_issue;
   logic [4:0]  mdu_issue_rd;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_data;
   logic        mdu_ready;
   logic [4:0]  read1;
   logic [4:0]  read2;
   logic        dec_wen;
   logic [4:0]  dec_rd;
   logic        stall;
   logic        write;
   logic [4:0]  reg_write;
   logic [31:0] wdata;
   logic [31:0] busy;

   modport master (
      output alu_valid, alu_rd, alu_data, mdu_issue, mdu_issue_rd,
             mdu_valid, mdu_rd, mdu_data, read1, read2, dec_wen, dec_rd,
      input  mdu_ready, stall, write, reg_write, wdata, busy
   );

   modport slave (
      input  alu_valid, alu_rd, alu_data, mdu_issue, mdu_issue_rd,
             mdu_valid, mdu_rd, mdu_data, read1, read2, dec_wen, dec_rd,
      output mdu_ready, stall, write, reg_write, wdata, busy
   );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between the ALU writeback and a buffered
// MDU result, and tracks pending MDU destinations to stall decode on hazards.
module regfile_wb_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   regfile_wb_arbiter_if.slave  bus
);
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

   buf_state_t  buf_state, buf_state_next;
   logic [4:0]  buf_rd;
   logic [31:0] buf_data;
   logic        buf_full, alu_win, drain, ready, load, starve;
   logic [3:0]  starve_count;
   logic [31:0] busy_q, busy_next;
   logic        write_q;
   logic [4:0]  reg_write_q;
   logic [31:0] wdata_q;

   assign buf_full = (buf_state == BUF_FULL);

   always_comb begin
      alu_win        = bus.alu_valid && (bus.alu_rd != 5'd0);
      drain          = buf_full && !alu_win;
      ready          = !buf_full || drain;
      // r0 results complete the handshake but never occupy the buffer
      load           = bus.mdu_valid && ready && (bus.mdu_rd != 5'd0);
      buf_state_next = buf_state;
      if (load)
         buf_state_next = BUF_FULL;
      else if (drain)
         buf_state_next = BUF_EMPTY;
   end

   // Clear first so a same-cycle issue to the draining register wins
   always_comb begin
      busy_next = busy_q;
      if (drain)
         busy_next[buf_rd] = 1'b0;
      if (bus.mdu_issue && (bus.mdu_issue_rd != 5'd0))
         busy_next[bus.mdu_issue_rd] = 1'b1;
      busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         buf_state <= BUF_EMPTY;
      else
         buf_state <= buf_state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_rd       <= '0;
         buf_data     <= '0;
         busy_q       <= '0;
         starve_count <= '0;
         write_q      <= 1'b0;
         reg_write_q  <= '0;
         wdata_q      <= '0;
      end else begin
         if (load) begin
            buf_rd   <= bus.mdu_rd;
            buf_data <= bus.mdu_data;
         end
         busy_q <= busy_next;
         if (alu_win) begin
            write_q     <= 1'b1;
            reg_write_q <= bus.alu_rd;
            wdata_q     <= bus.alu_data;
         end else if (drain) begin
            write_q     <= 1'b1;
            reg_write_q <= buf_rd;
            wdata_q     <= buf_data;
         end else begin
            write_q <= 1'b0;
         end
         if (!buf_full || drain)
            starve_count <= '0;
         else if (starve_count != LIMIT)
            starve_count <= starve_count + 4'd1;
      end
   end

   assign starve = (starve_count == LIMIT);

   assign bus.mdu_ready = ready;
   assign bus.write     = write_q;
   assign bus.reg_write = reg_write_q;
   assign bus.wdata     = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.stall     = ((bus.read1 != 5'd0) && busy_q[bus.read1])
                        | ((bus.read2 != 5'd0) && busy_q[bus.read2])
                        | (bus.dec_wen && (bus.dec_rd != 5'd0) && busy_q[bus.dec_rd])
                        | starve;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed expectations per scenario.
module tb_regfile_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned checks = 0;
   int unsigned failures = 0;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.mdu_issue = 1'b0; bus.mdu_issue_rd = '0;
      bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
      bus.read1 = '0; bus.read2 = '0; bus.dec_wen = 1'b0; bus.dec_rd = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      #2;
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL rst_write got=%0h exp=0", bus.write); end
      checks++; if (bus.reg_write !== 5'd0) begin failures++; $display("FAIL rst_reg_write got=%0h exp=0", bus.reg_write); end
      checks++; if (bus.wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata got=%0h exp=0", bus.wdata); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL rst_mdu_ready got=%0h exp=1", bus.mdu_ready); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%0h exp=0", bus.stall); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_alu();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEAD_BEEF;
      tick();
      checks++; if (bus.write !== 1'b1) begin failures++; $display("FAIL alu_write got=%0h exp=1", bus.write); end
      checks++; if (bus.reg_write !== 5'd5) begin failures++; $display("FAIL alu_reg_write got=%0h exp=5", bus.reg_write); end
      checks++; if (bus.wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_wdata got=%0h exp=deadbeef", bus.wdata); end
      bus.alu_rd = 5'd0; bus.alu_data = 32'h0000_0001;
      tick();
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL alu_r0_write got=%0h exp=0", bus.write); end
      checks++; if (bus.reg_write !== 5'd5) begin failures++; $display("FAIL alu_r0_hold_rd got=%0h exp=5", bus.reg_write); end
      checks++; if (bus.wdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL alu_r0_hold_data got=%0h exp=deadbeef", bus.wdata); end
      idle_inputs();
   endtask

   task automatic test_mdu_path();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd9;
      tick();
      bus.mdu_issue = 1'b0;
      checks++; if (bus.busy !== 32'h0000_0200) begin failures++; $display("FAIL mdu_busy_set got=%0h exp=200", bus.busy); end
      bus.read1 = 5'd9; #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mdu_raw_stall got=%0h exp=1", bus.stall); end
      bus.read1 = 5'd0; bus.dec_wen = 1'b1; bus.dec_rd = 5'd9; #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mdu_waw_stall got=%0h exp=1", bus.stall); end
      bus.dec_wen = 1'b0; bus.read1 = 5'd9;
      tick();
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_1234; #1;
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL mdu_ready_idle got=%0h exp=1", bus.mdu_ready); end
      tick();
      bus.mdu_valid = 1'b0;
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL mdu_no_early_write got=%0h exp=0", bus.write); end
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL mdu_stall_hold got=%0h exp=1", bus.stall); end
      tick();
      checks++; if (bus.write !== 1'b1) begin failures++; $display("FAIL mdu_write got=%0h exp=1", bus.write); end
      checks++; if (bus.reg_write !== 5'd9) begin failures++; $display("FAIL mdu_reg_write got=%0h exp=9", bus.reg_write); end
      checks++; if (bus.wdata !== 32'h0000_1234) begin failures++; $display("FAIL mdu_wdata got=%0h exp=1234", bus.wdata); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL mdu_busy_clear got=%0h exp=0", bus.busy); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mdu_stall_release got=%0h exp=0", bus.stall); end
      idle_inputs();
   endtask

   task automatic test_mdu_zero();
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h0000_FFFF; #1;
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL mdu0_ready got=%0h exp=1", bus.mdu_ready); end
      tick();
      bus.mdu_valid = 1'b0;
      tick();
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL mdu0_discard got=%0h exp=0", bus.write); end
      checks++; if (bus.wdata !== 32'h0000_1234) begin failures++; $display("FAIL mdu0_hold_data got=%0h exp=1234", bus.wdata); end
      idle_inputs();
   endtask

   task automatic test_contention();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd12;
      tick();
      bus.mdu_issue = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd12; bus.mdu_data = 32'h0000_ABCD;
      tick();
      bus.mdu_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h100 + 32'(i); #1;
         checks++; if (bus.mdu_ready !== 1'b0) begin failures++; $display("FAIL cont_ready[%0d] got=%0h exp=0", i, bus.mdu_ready); end
         checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL cont_stall_early[%0d] got=%0h exp=0", i, bus.stall); end
         tick();
         checks++; if (bus.wdata !== 32'h100 + 32'(i)) begin failures++; $display("FAIL cont_alu_wdata[%0d] got=%0h exp=%0h", i, bus.wdata, 32'h100 + 32'(i)); end
      end
      bus.alu_valid = 1'b0; #1;
      checks++; if (bus.stall !== 1'b1) begin failures++; $display("FAIL cont_starve_stall got=%0h exp=1", bus.stall); end
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL cont_drain_ready got=%0h exp=1", bus.mdu_ready); end
      tick();
      checks++; if (bus.write !== 1'b1) begin failures++; $display("FAIL cont_write got=%0h exp=1", bus.write); end
      checks++; if (bus.reg_write !== 5'd12) begin failures++; $display("FAIL cont_reg_write got=%0h exp=c", bus.reg_write); end
      checks++; if (bus.wdata !== 32'h0000_ABCD) begin failures++; $display("FAIL cont_wdata got=%0h exp=abcd", bus.wdata); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL cont_busy got=%0h exp=0", bus.busy); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL cont_counter_reset got=%0h exp=0", bus.stall); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd3;
      tick();
      bus.mdu_issue_rd = 5'd4;
      tick();
      bus.mdu_issue = 1'b0;
      checks++; if (bus.busy !== 32'h0000_0018) begin failures++; $display("FAIL b2b_busy_set got=%0h exp=18", bus.busy); end
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h33; #1;
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready0 got=%0h exp=1", bus.mdu_ready); end
      tick();
      bus.mdu_rd = 5'd4; bus.mdu_data = 32'h44; #1;
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready1 got=%0h exp=1", bus.mdu_ready); end
      tick();
      bus.mdu_valid = 1'b0;
      checks++; if (bus.write !== 1'b1 || bus.reg_write !== 5'd3 || bus.wdata !== 32'h33) begin failures++; $display("FAIL b2b_first got=%0h/%0h/%0h exp=1/3/33", bus.write, bus.reg_write, bus.wdata); end
      checks++; if (bus.busy !== 32'h0000_0010) begin failures++; $display("FAIL b2b_busy_mid got=%0h exp=10", bus.busy); end
      tick();
      checks++; if (bus.write !== 1'b1 || bus.reg_write !== 5'd4 || bus.wdata !== 32'h44) begin failures++; $display("FAIL b2b_second got=%0h/%0h/%0h exp=1/4/44", bus.write, bus.reg_write, bus.wdata); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL b2b_busy_end got=%0h exp=0", bus.busy); end
      idle_inputs();
   endtask

   task automatic test_collision();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
      tick();
      bus.mdu_issue = 1'b0;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h77;
      tick();
      bus.mdu_valid = 1'b0;
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd7;
      tick();
      bus.mdu_issue = 1'b0;
      checks++; if (bus.write !== 1'b1 || bus.reg_write !== 5'd7 || bus.wdata !== 32'h77) begin failures++; $display("FAIL coll_write got=%0h/%0h/%0h exp=1/7/77", bus.write, bus.reg_write, bus.wdata); end
      checks++; if (bus.busy !== 32'h0000_0080) begin failures++; $display("FAIL coll_busy_kept got=%0h exp=80", bus.busy); end
      bus.mdu_valid = 1'b1; bus.mdu_data = 32'h78;
      tick();
      bus.mdu_valid = 1'b0;
      tick();
      checks++; if (bus.wdata !== 32'h78 || bus.busy !== 32'd0) begin failures++; $display("FAIL coll_second got=%0h/%0h exp=78/0", bus.wdata, bus.busy); end
      idle_inputs();
   endtask

   task automatic test_reset_midstream();
      bus.mdu_issue = 1'b1; bus.mdu_issue_rd = 5'd2;
      tick();
      bus.mdu_issue_rd = 5'd8;
      bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd2; bus.mdu_data = 32'h55;
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
      tick();
      bus.mdu_issue = 1'b0; bus.mdu_valid = 1'b0;
      bus.read1 = 5'd2; bus.read2 = 5'd8; #1;
      checks++; if (bus.busy !== 32'h0000_0104) begin failures++; $display("FAIL mid_busy_pre got=%0h exp=104", bus.busy); end
      checks++; if (bus.mdu_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_pre got=%0h exp=0", bus.mdu_ready); end
      rst = 1'b1; #1;
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL mid_rst_write got=%0h exp=0", bus.write); end
      checks++; if (bus.busy !== 32'd0) begin failures++; $display("FAIL mid_rst_busy got=%0h exp=0", bus.busy); end
      checks++; if (bus.mdu_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_ready got=%0h exp=1", bus.mdu_ready); end
      checks++; if (bus.stall !== 1'b0) begin failures++; $display("FAIL mid_rst_stall got=%0h exp=0", bus.stall); end
      rst = 1'b0;
      idle_inputs();
      tick();
      checks++; if (bus.write !== 1'b0) begin failures++; $display("FAIL mid_buffer_dropped got=%0h exp=0", bus.write); end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_mdu_path();
      test_mdu_zero();
      test_contention();
      test_back_to_back();
      test_collision();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and pending-write scoreboard for the 32x32 MIPS register file. It shares the register file's single write port between the single-cycle ALU writeback path and the multi-cycle multiply/divide unit (MDU), which returns results through a valid/ready handshake. It tracks destination registers with MDU results still outstanding and raises a decode stall on RAW/WAW hazards against them. It sits between the writeback stage and the register file's `write`/`reg_write`/`wdata` inputs.

## Interface
- STARVE_LIMIT, 4: consecutive lost arbitration cycles of a buffered MDU result before `stall` is forced; range 1–15.

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- alu_valid  in  1  ALU writeback present this cycle; cannot be back-pressured
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mdu_issue  in  1  MDU operation issued from decode this cycle
- mdu_issue_rd  in  5  destination of the issued MDU operation
- mdu_valid  in  1  MDU result offered
- mdu_rd  in  5  MDU result destination
- mdu_data  in  32  MDU result
- mdu_ready  out  1  arbiter accepts MDU result this cycle
- read1, read2  in  5  decode-stage source registers
- dec_wen  in  1  decode-stage instruction writes a register
- dec_rd  in  5  decode-stage destination register
- stall  out  1  freeze decode/fetch (combinational)
- write  out  1  register-file write enable (registered)
- reg_write  out  5  register-file write address (registered)
- wdata  out  32  register-file write data (registered)
- busy  out  32  scoreboard bits, bit i = result pending for register i

## Operation
- alu_win = alu_valid & (alu_rd != 0). An ALU writeback to r0 is treated as idle.
- One-entry MDU buffer (buf_full, buf_rd, buf_data).
  - drain = buf_full & !alu_win.
  - mdu_ready = !buf_full | drain (combinational).
  - A handshake (mdu_valid & mdu_ready) loads the buffer. A simultaneous drain and load is legal; the buffer stays full with the new entry.
  - An MDU result with mdu_rd = 0 is accepted and discarded: the buffer is not loaded.
- Output register update at each edge, priority order:
  1. alu_win → write=1, reg_write=alu_rd, wdata=alu_data.
  2. else drain → write=1, reg_write=buf_rd, wdata=buf_data; buffer cleared unless reloaded.
  3. else write=0; reg_write/wdata hold their previous values.
- Scoreboard:
  - mdu_issue & mdu_issue_rd != 0 sets busy[mdu_issue_rd].
  - A drain clears busy[buf_rd].
  - Set and clear of the same bit in the same cycle: set wins.
  - busy[0] is always 0.
- Starvation counter (4 bits):
  - Increments each cycle that buf_full & alu_win.
  - Resets to 0 when the buffer drains or is empty.
  - Saturates at STARVE_LIMIT.
  - starve = (count == STARVE_LIMIT).
- stall = (read1 != 0 & busy[read1]) | (read2 != 0 & busy[read2]) | (dec_wen & dec_rd != 0 & busy[dec_rd]) | starve.
- The ALU path never writes a busy register: the WAW check in stall guarantees it.
- Reset (async, immediate):
  - write=0, reg_write=0, wdata=0.
  - buffer empty, busy=0, counter=0.
  - Hence mdu_ready=1 and stall=0 while rst is high.

## Timing
- ALU latency 1: alu_valid in cycle N → write/reg_write/wdata valid in cycle N+1.
- MDU latency ≥2:
  - Handshake in N → buffer full in N+1.
  - Written in N+2 if the ALU is idle in N+1; otherwise delayed one cycle per cycle of ALU activity.
- busy[rd] clears at the same edge the write outputs take the MDU result. During that write cycle the register file forwards wdata to matching reads, so reads released by the cleared stall see the new value.
- busy[rd] set by mdu_issue in N is visible (and stalls) from N+1.
- Sustained MDU throughput is one result per cycle when the ALU is idle.
- Reset asserted mid-transfer drops the buffered result and all busy bits. The MDU must also be reset.

## Test plan
- Reset: assert rst mid-stream with buffer full and busy=0x0000_0104 → immediately write=0, busy=0, mdu_ready=1, stall=0.
- ALU only: alu_valid, rd=5, data=0xDEAD_BEEF in cycle 1 → cycle 2 write=1, reg_write=5, wdata=0xDEAD_BEEF. With rd=0 → write=0.
- MDU path, ALU idle:
  - mdu_issue rd=9 in cycle 1 → busy[9]=1 from cycle 2.
  - In cycle 3, read1=9 → stall=1.
  - Handshake rd=9, data=0x1234 in cycle 4 → write of r9=0x1234 in cycle 6, busy[9]=0 in cycle 6, stall=0 in cycle 6.
- Contention: MDU result buffered, then alu_valid for 4 consecutive cycles with STARVE_LIMIT=4 → mdu_ready=0 throughout; stall=1 after the 4th lost cycle; MDU write occurs the cycle after alu_valid drops; counter returns to 0.
- Back-to-back MDU results rd=3 then rd=4 with the ALU idle → mdu_ready stays 1, consecutive writes r3 then r4, and both busy bits clear.
- Set/clear collision: drain of rd=7 in the same cycle as mdu_issue rd=7 → busy[7] remains 1 and r7 is written with the old result.
